// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that feeds one UART transmitter from NUM_REQ byte requesters,
// with an optional per-requester lock to keep the grant across consecutive bytes.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic [NUM_REQ-1:0]         i_Req_Valid,
  input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
  input  logic [NUM_REQ-1:0]         i_Req_Lock,
  output logic [NUM_REQ-1:0]         o_Req_Ack,
  output logic                       o_Tx_DV,
  output logic [7:0]                 o_Tx_Byte,
  input  logic                       i_Tx_Active,
  input  logic                       i_Tx_Done,
  output logic [$clog2(NUM_REQ)-1:0] o_Grant_Id,
  output logic                       o_Busy,
  output logic                       o_Locked
);

  localparam int          IW = $clog2(NUM_REQ);
  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE, RELEASE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 dv_q, dv_d;
  logic [7:0]           byte_q, byte_d;
  logic [IW-1:0]        gid_q, gid_d;
  logic                 busy_q, busy_d;
  logic                 locked_q, locked_d;

  logic                 lock_hold;
  logic [NUM_REQ-1:0]   owner_mask;
  logic [NUM_REQ-1:0]   elig;
  logic [IW-1:0]        cand;
  logic [IW-1:0]        sel;
  logic                 found;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      ack_q    <= '0;
      dv_q     <= 1'b0;
      byte_q   <= '0;
      gid_q    <= '0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ack_q    <= ack_d;
      dv_q     <= dv_d;
      byte_q   <= byte_d;
      gid_q    <= gid_d;
      busy_q   <= busy_d;
      locked_q <= locked_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    ack_d      = '0;
    dv_d       = 1'b0;
    byte_d     = byte_q;
    gid_d      = gid_q;
    locked_d   = locked_q;
    owner_mask = '0;
    cand       = '0;
    sel        = '0;
    found      = 1'b0;

    // A lock whose owner has already dropped i_Req_Lock no longer restricts eligibility.
    lock_hold  = locked_q && i_Req_Lock[gid_q];
    owner_mask[gid_q] = 1'b1;
    elig       = lock_hold ? (i_Req_Valid & owner_mask) : i_Req_Valid;

    for (int unsigned i = 0; i < NR; i++) begin
      cand = IW'((32'(ptr_q) + i) % NR);
      if (!found && elig[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (locked_q && !lock_hold) locked_d = 1'b0;
        if (!i_Tx_Active && !i_Tx_Done && found) begin
          state_d    = SEND;
          ack_d[sel] = 1'b1;
          dv_d       = 1'b1;
          byte_d     = i_Req_Byte[{sel, 3'b000} +: 8];
          gid_d      = sel;
          ptr_d      = (sel == IW'(NR - 1)) ? '0 : sel + IW'(1);
          locked_d   = i_Req_Lock[sel];
        end
      end
      SEND:      if (i_Tx_Active) state_d = WAIT_DONE;
      WAIT_DONE: if (i_Tx_Done)   state_d = RELEASE;
      RELEASE:   if (!i_Tx_Done)  state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign o_Req_Ack  = ack_q;
  assign o_Tx_DV    = dv_q;
  assign o_Tx_Byte  = byte_q;
  assign o_Grant_Id = gid_q;
  assign o_Busy     = busy_q;
  assign o_Locked   = locked_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle vector table with the transmitter flags
// driven directly, then multi-frame sequences against a simple transmitter model.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int CPB = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  valid, lock;
  logic [8*N-1:0] req_bytes;
  logic          tb_act, tb_done, model_en;
  logic          tx_act, tx_done;
  logic [N-1:0]  o_Req_Ack;
  logic          o_Tx_DV;
  logic [7:0]    o_Tx_Byte;
  logic [1:0]    o_Grant_Id;
  logic          o_Busy, o_Locked;

  logic          m_act = 1'b0, m_done = 1'b0;
  int            m_cnt = 0;
  logic [7:0]    fr_byte[$];
  logic [1:0]    fr_id[$];

  int checks = 0, errors = 0;
  int ack_cnt[N];
  logic [N-1:0] drop_mask;
  logic lock_seq;
  int n1, fb;

  always #5 clk = ~clk;

  assign tx_act  = model_en ? m_act  : tb_act;
  assign tx_done = model_en ? m_done : tb_done;

  uart_tx_arbiter #(.NUM_REQ(N)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Req_Valid(valid), .i_Req_Byte(req_bytes),
    .i_Req_Lock(lock), .o_Req_Ack(o_Req_Ack), .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte),
    .i_Tx_Active(tx_act), .i_Tx_Done(tx_done), .o_Grant_Id(o_Grant_Id),
    .o_Busy(o_Busy), .o_Locked(o_Locked)
  );

  // Transmitter model: 10 bit times active, then Done high for two cycles; not reset by i_Reset.
  always @(posedge clk) begin
    m_done <= 1'b0;
    if (!model_en) begin
      m_act <= 1'b0;
      m_cnt <= 0;
    end else if (m_act) begin
      if (m_cnt == 10*CPB - 1) begin
        m_act  <= 1'b0;
        m_done <= 1'b1;
        m_cnt  <= 10*CPB;
      end else m_cnt <= m_cnt + 1;
    end else if (m_cnt == 10*CPB) begin
      m_done <= 1'b1;
      m_cnt  <= 0;
    end else if (o_Tx_DV) begin
      m_act <= 1'b1;
      m_cnt <= 0;
      fr_byte.push_back(o_Tx_Byte);
      fr_id.push_back(o_Grant_Id);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (o_Req_Ack != '0) begin
      chk("ack_onehot", 32'($countones(o_Req_Ack)), 32'd1);
      for (int k = 0; k < N; k++) if (o_Req_Ack[k]) ack_cnt[k]++;
      valid = valid & ~(o_Req_Ack & drop_mask);
      if (lock_seq && o_Req_Ack[1]) begin
        n1++;
        if (n1 == 3) begin
          lock[1]  = 1'b0;
          valid[1] = 1'b0;
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < N; k++) ack_cnt[k] = 0;
    fb = fr_byte.size();
    n1 = 0;
  endtask

  task automatic wait_frames(input int n);
    for (int c = 0; c < 3000 && (fr_byte.size() - fb) < n; c++) step();
    chk("frame_count_reached", 32'(fr_byte.size() - fb), 32'(n));
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 500 && (o_Busy || m_act || m_done); c++) step();
    step();
    chk("settle_idle", 32'({o_Busy, m_act, m_done}), 32'd0);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] valid, lock;
    logic       act, done;
    logic [3:0] ack;
    logic       dv;
    logic [1:0] gid;
    logic       busy, locked;
    logic [7:0] tx_byte;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic a,
                     input logic d, input logic [3:0] ek, input logic edv, input logic [1:0] eg,
                     input logic eb, input logic el, input logic [7:0] ey);
    vec_t t;
    t.rst = r; t.valid = v; t.lock = l; t.act = a; t.done = d;
    t.ack = ek; t.dv = edv; t.gid = eg; t.busy = eb; t.locked = el; t.tx_byte = ey;
    vecs.push_back(t);
  endtask

  initial begin
    rst = 1'b1; valid = '0; lock = '0; tb_act = 1'b0; tb_done = 1'b0; model_en = 1'b0;
    drop_mask = '0; lock_seq = 1'b0; n1 = 0; fb = 0;
    req_bytes = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int k = 0; k < N; k++) ack_cnt[k] = 0;

    //  rst valid    lock     act  done  ack      dv  gid  busy lck byte
    add(1, 4'b1111, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 0, 0, 8'h00);
    add(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 1, 2'd0, 1, 0, 8'h10);
    add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 1, 0, 8'h10);
    add(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 1, 0, 8'h10);
    add(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 1, 0, 8'h10);
    add(0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 2'd0, 1, 0, 8'h10);
    add(0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 2'd0, 1, 0, 8'h10);
    add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 0, 0, 8'h10);
    add(0, 4'b1111, 4'b0000, 0, 0, 4'b0010, 1, 2'd1, 1, 0, 8'h11);
    add(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd1, 1, 0, 8'h11);
    add(0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 2'd1, 1, 0, 8'h11);
    add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 2'd1, 0, 0, 8'h11);
    add(0, 4'b1111, 4'b0000, 1, 0, 4'b0000, 0, 2'd1, 0, 0, 8'h11);
    add(0, 4'b1111, 4'b0000, 0, 1, 4'b0000, 0, 2'd1, 0, 0, 8'h11);
    add(0, 4'b0001, 4'b0000, 0, 0, 4'b0001, 1, 2'd0, 1, 0, 8'h10);
    add(0, 4'b0000, 4'b0000, 1, 0, 4'b0000, 0, 2'd0, 1, 0, 8'h10);
    add(0, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 2'd0, 1, 0, 8'h10);
    add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 2'd0, 0, 0, 8'h10);
    add(0, 4'b0100, 4'b0100, 0, 0, 4'b0100, 1, 2'd2, 1, 1, 8'h12);
    add(0, 4'b0000, 4'b0100, 1, 0, 4'b0000, 0, 2'd2, 1, 1, 8'h12);
    add(0, 4'b0000, 4'b0100, 0, 1, 4'b0000, 0, 2'd2, 1, 1, 8'h12);
    add(0, 4'b0000, 4'b0100, 0, 0, 4'b0000, 0, 2'd2, 0, 1, 8'h12);
    add(0, 4'b1011, 4'b0100, 0, 0, 4'b0000, 0, 2'd2, 0, 1, 8'h12);
    add(0, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 2'd2, 0, 0, 8'h12);
    add(0, 4'b1011, 4'b0000, 0, 0, 4'b1000, 1, 2'd3, 1, 0, 8'h13);
    add(1, 4'b1111, 4'b1111, 1, 1, 4'b0000, 0, 2'd0, 0, 0, 8'h00);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; valid = vecs[i].valid; lock = vecs[i].lock;
      tb_act = vecs[i].act; tb_done = vecs[i].done;
      step();
      chk($sformatf("vec%0d_ack", i),    32'(o_Req_Ack),  32'(vecs[i].ack));
      chk($sformatf("vec%0d_dv", i),     32'(o_Tx_DV),    32'(vecs[i].dv));
      chk($sformatf("vec%0d_gid", i),    32'(o_Grant_Id), 32'(vecs[i].gid));
      chk($sformatf("vec%0d_busy", i),   32'(o_Busy),     32'(vecs[i].busy));
      chk($sformatf("vec%0d_locked", i), 32'(o_Locked),   32'(vecs[i].locked));
      chk($sformatf("vec%0d_byte", i),   32'(o_Tx_Byte),  32'(vecs[i].tx_byte));
    end
    rst = 1'b0; valid = '0; lock = '0; tb_act = 1'b0; tb_done = 1'b0;
    model_en = 1'b1;
    step();

    // All four requesters valid: grants 0,1,2,3, one ack each.
    do_reset();
    drop_mask = 4'b1111; valid = 4'b1111;
    wait_frames(4);
    wait_idle();
    for (int k = 0; k < N; k++) begin
      chk($sformatf("rr_id%0d", k),   32'(fr_id[fb+k]),   32'(k));
      chk($sformatf("rr_byte%0d", k), 32'(fr_byte[fb+k]), 32'(8'h10 + k));
      chk($sformatf("rr_acks%0d", k), 32'(ack_cnt[k]),    32'd1);
    end

    // Fairness: requester 0 held valid, requester 2 joins at cycle 5.
    do_reset();
    drop_mask = '0; valid = 4'b0001;
    for (int c = 0; c < 5; c++) step();
    valid = 4'b0101;
    wait_frames(4);
    valid = '0;
    wait_idle();
    for (int k = 0; k < 4; k++)
      chk($sformatf("fair_id%0d", k), 32'(fr_id[fb+k]), (k % 2 == 0) ? 32'd0 : 32'd2);

    // Lock: requester 1 keeps the grant for three bytes while requester 3 waits.
    do_reset();
    drop_mask = 4'b1000; lock = 4'b0010; valid = 4'b1010; lock_seq = 1'b1;
    wait_frames(4);
    wait_idle();
    lock_seq = 1'b0;
    for (int k = 0; k < 4; k++)
      chk($sformatf("lock_id%0d", k), 32'(fr_id[fb+k]), (k < 3) ? 32'd1 : 32'd3);
    chk("lock_acks1", 32'(ack_cnt[1]), 32'd3);
    chk("lock_released", 32'(o_Locked), 32'd0);

    // Withdrawal: requester 2 drops valid before it can be granted.
    do_reset();
    drop_mask = 4'b0001; valid = 4'b0001;
    for (int c = 0; c < 100 && !m_act; c++) step();
    valid[2] = 1'b1;
    for (int c = 0; c < 5; c++) step();
    valid[2] = 1'b0;
    wait_idle();
    for (int c = 0; c < 5; c++) step();
    chk("wd_acks2", 32'(ack_cnt[2]), 32'd0);
    chk("wd_frames", 32'(fr_byte.size() - fb), 32'd1);

    // Single 0xA5 request, then reset during data bit 3.
    do_reset();
    req_bytes[7:0] = 8'hA5; drop_mask = 4'b0001; valid = 4'b0001;
    wait_frames(1);
    chk("single_byte", 32'(fr_byte[fb]), 32'hA5);
    chk("single_acks0", 32'(ack_cnt[0]), 32'd1);
    for (int c = 0; c < 200 && !(m_act && m_cnt == 4*CPB + 1); c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_outputs", 32'({o_Req_Ack, o_Tx_DV, o_Tx_Byte, o_Grant_Id, o_Busy, o_Locked}), 32'd0);
    chk("rst_tx_still_active", 32'(m_act), 32'd1);
    req_bytes[15:8] = 8'h3C; drop_mask = 4'b0010; valid = 4'b0010;
    begin
      int early = 0;
      for (int c = 0; c < 200 && (m_act || m_done); c++) begin
        step();
        if (o_Tx_DV && (m_act || m_done)) early++;
      end
      chk("rst_no_dv_while_tx", 32'(early), 32'd0);
    end
    wait_frames(2);
    wait_idle();
    chk("rst_next_byte", 32'(fr_byte[fb+1]), 32'h3C);
    chk("rst_next_id", 32'(fr_id[fb+1]), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, the number of requesters (2..8).
REQ-002 The block SHALL have ports: i_Clock, input, 1, the single clock; all logic on its rising edge.
REQ-003 The block SHALL have ports: i_Reset, input, 1, synchronous, active-high reset.
REQ-004 The block SHALL have ports: i_Req_Valid, input, NUM_REQ, requester k has a byte pending.
REQ-005 The block SHALL have ports: i_Req_Byte, input, 8*NUM_REQ, byte of requester k at bits [8k+7:8k].
REQ-006 The block SHALL have ports: i_Req_Lock, input, NUM_REQ, requester k asks to keep the grant for its next byte.
REQ-007 The block SHALL have ports: o_Req_Ack, output, NUM_REQ, one-cycle pulse: byte of requester k captured.
REQ-008 The block SHALL have ports: o_Tx_DV, output, 1, one-cycle start strobe to the transmitter.
REQ-009 The block SHALL have ports: o_Tx_Byte, output, 8, byte to the transmitter, held stable until the next grant.
REQ-010 The block SHALL have ports: i_Tx_Active, input, 1, transmitter active flag.
REQ-011 The block SHALL have ports: i_Tx_Done, input, 1, transmitter done flag (high for two cycles at frame end).
REQ-012 The block SHALL have ports: o_Grant_Id, output, $clog2(NUM_REQ), index of the last granted requester.
REQ-013 The block SHALL have ports: o_Busy, output, 1, high whenever state is not IDLE.
REQ-014 The block SHALL have ports: o_Locked, output, 1, lock held by o_Grant_Id.

Function
REQ-015 States SHALL be IDLE, SEND, WAIT_DONE, RELEASE; all outputs registered.
REQ-016 IDLE SHALL grant only when i_Tx_Active=0, i_Tx_Done=0 and at least one eligible i_Req_Valid bit is set.
REQ-017 Eligibility SHALL be: all requesters when o_Locked=0; only o_Grant_Id when o_Locked=1.
REQ-018 Selection SHALL be round-robin: first eligible valid requester at or above pointer, wrapping modulo NUM_REQ.
REQ-019 On grant of k in cycle t, cycle t+1 SHALL show o_Req_Ack[k]=1, o_Tx_DV=1, o_Tx_Byte=byte k, o_Grant_Id=k, state SEND.
REQ-020 On grant of k, the pointer SHALL become (k+1) mod NUM_REQ, and o_Locked SHALL become i_Req_Lock[k].
REQ-021 o_Req_Ack and o_Tx_DV SHALL each be high exactly one cycle per grant; never more than one o_Req_Ack bit is high.
REQ-022 In IDLE with o_Locked=1 and i_Req_Lock[o_Grant_Id]=0, o_Locked SHALL clear that cycle.
REQ-023 A lock SHALL be held while the owner has i_Req_Lock high, even when its i_Req_Valid is low; in that case no requester is granted.
REQ-024 SEND SHALL go to WAIT_DONE when i_Tx_Active=1.
REQ-025 WAIT_DONE SHALL go to RELEASE when i_Tx_Done=1.
REQ-026 RELEASE SHALL go to IDLE when i_Tx_Done=0, so one frame is never counted twice.
REQ-027 A requester SHALL keep i_Req_Valid and its byte stable until acked; dropping valid before ack withdraws the request without error.
REQ-028 Simultaneous valids SHALL be resolved solely by the pointer; a requester with valid held high SHALL be granted within NUM_REQ grants.
REQ-029 Back-to-back throughput SHALL be one byte per transmitter frame plus at most 2 idle cycles.

Reset
REQ-030 While i_Reset=1 at a clock edge, the block SHALL set state IDLE, pointer 0, o_Req_Ack=0, o_Tx_DV=0, o_Tx_Byte=0, o_Grant_Id=0, o_Busy=0 and o_Locked=0.
REQ-031 i_Reset SHALL override all other inputs.
REQ-032 After reset during a frame, the transmitter is not reset; per REQ-016, no grant SHALL occur until i_Tx_Active=0 and i_Tx_Done=0.

Verification
REQ-033 Single request: NUM_REQ=4, CLKS_PER_BIT=4, i_Req_Valid=0001, byte 0xA5 -> one o_Req_Ack[0] and one o_Tx_DV pulse; serial line shows 0xA5; o_Busy drops after Done falls.
REQ-034 All four valid, bytes 0x10..0x13 -> grants in order 0,1,2,3; exactly four frames; exactly one ack per requester.
REQ-035 Fairness: requester 0 always valid, requester 2 valid from cycle 5 -> grants alternate 0,2,0,2.
REQ-036 Lock: requester 1 sends 3 bytes with lock high while requester 3 is valid -> requester 3 is granted only after requester 1 drops lock in IDLE.
REQ-037 Reset mid-frame: assert i_Reset during data bit 3 -> outputs zero next cycle; no new o_Tx_DV until the transmitter reaches idle; the next request then completes normally.
REQ-038 Withdrawal: requester 2 raises valid, then drops it before grant while the transmitter is busy -> no ack and no frame for requester 2.
